// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// FSM states and the default datapath width.
package mdu_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_e;

  function automatic logic op_is_signed(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

  function automatic logic op_is_div(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Execute-stage request/response bundle between the pipeline (master)
// and the multiply/divide sequencer (slave).
interface mdu_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
);
  logic             start_i;
  mdu_op_e          op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             cancel_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, a_i, b_i, cancel_i,
    input  stall_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, cancel_i,
    output stall_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/div_iter.sv
// Restoring divider datapath on unsigned magnitudes: one shift-subtract
// step per enable; next-state values are exposed so the last step can retire directly.
module div_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_nxt_o,
  output logic [WIDTH-1:0] quo_nxt_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // The shifted remainder needs WIDTH+1 bits so a divisor above 2^(WIDTH-1) still compares correctly.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rem_nxt_o = rem_sh[WIDTH-1:0];
    quo_nxt_o = {quo_q[WIDTH-2:0], 1'b0};
    if (!diff[WIDTH]) begin
      rem_nxt_o = diff[WIDTH-1:0];
      quo_nxt_o = {quo_q[WIDTH-2:0], 1'b1};
    end

    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_nxt_o;
      quo_d = quo_nxt_o;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: stalls the pipeline while busy
// and presents HI/LO with a one-cycle done pulse.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input logic  clk,
  input logic  rst,
  mdu_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             mul_sgn_q, mul_sgn_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;

  logic               in_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_a_ext, mul_b_ext, product;
  logic               div_load, div_step;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic               accept;

  assign in_sgn = op_is_signed(bus.op_i);
  assign a_mag  = (in_sgn && bus.a_i[WIDTH-1]) ? -bus.a_i : bus.a_i;
  assign b_mag  = (in_sgn && bus.b_i[WIDTH-1]) ? -bus.b_i : bus.b_i;
  assign accept = (state_q == ST_IDLE) && bus.start_i && !bus.cancel_i;

  // One shared multiplier: zero or sign extension selects MULTU vs MULT.
  assign mul_a_ext = {{WIDTH{mul_sgn_q & a_q[WIDTH-1]}}, a_q};
  assign mul_b_ext = {{WIDTH{mul_sgn_q & b_q[WIDTH-1]}}, b_q};
  assign product   = mul_a_ext * mul_b_ext;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .rem_nxt_o  (rem_nxt),
    .quo_nxt_o  (quo_nxt)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    mul_sgn_d  = mul_sgn_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    div_load   = 1'b0;
    div_step   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_div(bus.op_i)) begin
            state_d    = ST_DIV;
            div_load   = 1'b1;
            cnt_d      = '0;
            neg_quo_d  = in_sgn && (bus.a_i[WIDTH-1] ^ bus.b_i[WIDTH-1]);
            neg_rem_d  = in_sgn && bus.a_i[WIDTH-1];
            div_zero_d = (bus.b_i == '0);
          end else begin
            state_d   = ST_MUL;
            a_d       = bus.a_i;
            b_d       = bus.b_i;
            mul_sgn_d = in_sgn;
          end
        end
      end
      ST_MUL: begin
        {hi_d, lo_d} = product;
        state_d      = ST_DONE;
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // A zero divisor yields an all-ones quotient and |a| remainder; fixing only the remainder sign restores hi = a.
          lo_d    = (neg_quo_q && !div_zero_q) ? -quo_nxt : quo_nxt;
          hi_d    = neg_rem_q ? -rem_nxt : rem_nxt;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (bus.cancel_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      mul_sgn_q  <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      mul_sgn_q  <= mul_sgn_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.stall_o = !bus.cancel_i &&
                       ((state_q == ST_IDLE && bus.start_i) ||
                        state_q == ST_MUL || state_q == ST_DIV);
  assign bus.busy_o  = (state_q == ST_MUL) || (state_q == ST_DIV);
  assign bus.done_o  = (state_q == ST_DONE);
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: multiply/divide results and latency,
// divide-by-zero and overflow corners, cancel, and asynchronous reset.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  mdu_if #(.WIDTH(W)) bus ();

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one request in the first IDLE cycle, holds it until done_o, and
  // checks latency, stall length, result hold and the HI/LO values.
  task automatic run_op(input string name, input mdu_op_e op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                        input int exp_cyc);
    int cyc;
    int done_cyc;
    int stall_cnt;
    logic [W-1:0] hi0, lo0;
    logic held;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    #1;
    check({name, "_idle_at_start"}, 64'(bus.busy_o), 64'(0));
    hi0 = bus.hi_o;
    lo0 = bus.lo_o;
    held = 1'b1;
    cyc = 0;
    done_cyc = -1;
    stall_cnt = 0;
    while (done_cyc < 0 && cyc < 80) begin
      if (bus.stall_o) stall_cnt++;
      if (bus.done_o) done_cyc = cyc;
      else begin
        if (bus.hi_o !== hi0 || bus.lo_o !== lo0) held = 1'b0;
        @(negedge clk);
        #1;
        cyc++;
      end
    end
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
    check({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_cyc));
    check({name, "_hilo_held"}, 64'(held), 64'(1));
    check({name, "_hi"}, 64'(bus.hi_o), 64'(exp_hi));
    check({name, "_lo"}, 64'(bus.lo_o), 64'(exp_lo));
  endtask

  initial begin
    int done_cnt;
    rst          = 1'b0;
    bus.start_i  = 1'b0;
    bus.op_i     = MDU_MULT;
    bus.a_i      = '0;
    bus.b_i      = '0;
    bus.cancel_i = 1'b0;

    #12;
    check("rst_busy", 64'(bus.busy_o), 64'(0));
    check("rst_done", 64'(bus.done_o), 64'(0));
    check("rst_hi", 64'(bus.hi_o), 64'(0));
    check("rst_lo", 64'(bus.lo_o), 64'(0));
    check("rst_stall_idle", 64'(bus.stall_o), 64'(0));
    bus.start_i = 1'b1;
    #1;
    check("rst_stall_follows_start", 64'(bus.stall_o), 64'(1));
    bus.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back: each op starts in the IDLE cycle right after the previous DONE.
    run_op("mult_neg2x3", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2);
    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2);
    run_op("mult_min_sq", MDU_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 2);
    run_op("div_m7_2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    run_op("divu_by0", MDU_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 33);
    run_op("div_neg_by0", MDU_DIV, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 33);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);

    // Cancel mid-divide: HI/LO must keep the overflow result.
    @(negedge clk);
    bus.start_i = 1'b0;
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = MDU_DIVU;
    bus.a_i     = 32'd100;
    bus.b_i     = 32'd7;
    repeat (10) @(negedge clk);
    bus.cancel_i = 1'b1;
    #1;
    check("cancel_stall_low", 64'(bus.stall_o), 64'(0));
    check("cancel_busy_before_edge", 64'(bus.busy_o), 64'(1));
    @(negedge clk);
    bus.cancel_i = 1'b0;
    bus.start_i  = 1'b0;
    #1;
    check("cancel_idle", 64'(bus.busy_o), 64'(0));
    check("cancel_hi_kept", 64'(bus.hi_o), 64'(0));
    check("cancel_lo_kept", 64'(bus.lo_o), 64'(32'h8000_0000));
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.done_o) done_cnt++;
    end
    check("cancel_no_done", 64'(done_cnt), 64'(0));

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = MDU_DIV;
    bus.a_i     = 32'hFFFF_FFF9;
    bus.b_i     = 32'd2;
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy_o), 64'(0));
    check("arst_done", 64'(bus.done_o), 64'(0));
    check("arst_hi", 64'(bus.hi_o), 64'(0));
    check("arst_lo", 64'(bus.lo_o), 64'(0));
    check("arst_stall_follows_start", 64'(bus.stall_o), 64'(1));
    bus.start_i = 1'b0;
    #1;
    check("arst_stall_low", 64'(bus.stall_o), 64'(0));
    @(negedge clk);
    #2;
    rst = 1'b1;
    run_op("divu_100_7", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);

    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    check("final_idle", 64'(bus.busy_o), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide sequencer for the execute stage. It accepts a MULT/MULTU/DIV/DIVU request from the decoded instruction in E and runs a registered multiply or a 32-iteration restoring divide. While the operation is in flight it holds the pipeline through a stall request. It delivers the HI/LO pair with a one-cycle done pulse, which the HI/LO register write (hilowrite path) qualifies on.

## Interface
- WIDTH, 32, operand and result width; the iteration count equals WIDTH.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start_i  in  1  E-stage instruction is a mul/div; held high with stable operands while stall_o=1.
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i in IDLE.
- a_i  in  WIDTH  rs operand (dividend / multiplicand).
- b_i  in  WIDTH  rt operand (divisor / multiplier).
- cancel_i  in  1  flush of E (exception/flushE); aborts the current operation.
- stall_o  out  1  hold F/D/E stages.
- busy_o  out  1  state is MUL or DIV.
- done_o  out  1  hi_o/lo_o valid this cycle; one-cycle pulse.
- hi_o  out  WIDTH  product high half / remainder.
- lo_o  out  WIDTH  product low half / quotient.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start_i & !cancel_i & op_i[1]=0 -> MUL. Operands and op are latched.
  - start_i & !cancel_i & op_i[1]=1 -> DIV. Latches |a|, |b| (signed op) or raw values, the sign flags, and counter=0.
- MUL: one cycle. The 2*WIDTH product (signed or unsigned per op) is registered into {hi_o,lo_o}, then -> DONE.
- DIV: one restoring shift-subtract step per cycle on magnitudes; counter increments 0..WIDTH-1.
  - When counter=WIDTH-1 the step completes, sign fixup is applied, hi_o/lo_o are loaded, then -> DONE.
  - Sign fixup: quotient negated if sign(a)^sign(b); remainder takes the sign of a.
- DONE: done_o=1, stall_o=0, the pipeline advances; unconditionally -> IDLE. A start_i still high in DONE belongs to the finished instruction and is ignored.
- stall_o = (IDLE & start_i & !cancel_i) | MUL | DIV. It is combinational, and it is 0 whenever cancel_i=1.
- cancel_i: any state -> IDLE next edge. No done_o; hi_o/lo_o keep their previous values. Cancel has priority over start.
- Divide by zero: lo_o = all ones, hi_o = a_i (unsigned and signed alike, no sign fixup). No trap.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo_o=0x80000000, hi_o=0. This falls out of the magnitude algorithm with WIDTH+1-bit remainder arithmetic.
- hi_o/lo_o change only on the MUL->DONE or DIV->DONE edge.

## Timing
- Reset: state=IDLE, counter=0, hi_o=lo_o=0, done_o=0, busy_o=0, stall_o follows start_i combinationally.
- MULT/MULTU, start seen at cycle 0 in IDLE:
  - cycle 1 is MUL;
  - cycle 2 is DONE with done_o=1;
  - stall_o=1 in cycles 0-1.
- DIV/DIVU, start at cycle 0:
  - cycles 1..WIDTH are DIV;
  - cycle WIDTH+1 is DONE;
  - stall_o=1 for WIDTH+1 cycles (33 at WIDTH=32).
- Back-to-back: a new start is accepted only in IDLE, so the minimum spacing is one IDLE cycle after DONE. The new E instruction arrives in that cycle.
- Reset asserted mid-operation: immediate return to reset values, no done_o.

## Structure
- Shared package mdu_pkg: op encodings (MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU), state enum, default WIDTH.
- Sub-module div_iter: the divider datapath.
  - Holds the remainder/quotient registers and one shift-subtract step per enable.
  - Controlled by mdu_ctrl's counter and FSM.
- The multiply stays inline in mdu_ctrl as a single registered product.

## Test plan
- MULT a=0xFFFFFFFE (-2), b=3 -> done_o at cycle 2, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA; stall_o high exactly 2 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> done_o at cycle 33, lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1); stall_o high 33 cycles.
- DIVU a=100, b=0 -> lo_o=0xFFFFFFFF, hi_o=100. DIV a=0x80000000, b=0xFFFFFFFF -> lo_o=0x80000000, hi_o=0.
- DIVU a=100, b=7, cancel_i pulsed at cycle 10 -> IDLE at cycle 11, no done_o, hi_o/lo_o unchanged, stall_o=0 from cycle 10.
- rst driven low at cycle 5 of a DIV, asynchronous to clk -> outputs immediately at reset values. A following DIVU 100/7 after release -> lo_o=14, hi_o=2.
